// File: rtl/neuron_pkg.sv
// neuron_pkg: shared fp32 constants, IEEE-754 field widths and helpers for
// the Izhikevich neuron core and its fp32 arithmetic unit.
package neuron_pkg;

  // IEEE-754 single-precision field layout
  localparam int SIGN_W   = 1;
  localparam int EXP_W    = 8;
  localparam int MANT_W   = 23;
  localparam int EXP_BIAS = 127;

  // Model constants (fp32 bit patterns)
  localparam logic [31:0] FP_0P04  = 32'h3D23D70A;  // 0.04
  localparam logic [31:0] FP_5     = 32'h40A00000;  // 5.0
  localparam logic [31:0] FP_140   = 32'h430C0000;  // 140.0
  localparam logic [31:0] FP_30    = 32'h41F00000;  // 30.0 (spike threshold)
  localparam logic [31:0] FP_NEG65 = 32'hC2820000;  // -65.0
  localparam logic [31:0] FP_NEG13 = 32'hC1500000;  // -13.0
  localparam logic [31:0] FP_QNAN  = 32'h7FC00000;  // canonical quiet NaN

  typedef enum logic {FP_ADD = 1'b0, FP_MUL = 1'b1} fp_op_e;

  // Leading-zero count of a 27-bit value (27 when the value is zero)
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (found) begin
        n = n;
      end else if (v[i]) begin
        found = 1'b1;
      end else begin
        n = n + 5'd1;
      end
    end
    return n;
  endfunction

  // Round-to-nearest-even and pack. sig carries the leading one in bit 23,
  // e is the biased exponent before rounding. Results that end up below the
  // normal range flush to signed zero, above it saturate to signed infinity.
  function automatic logic [31:0] fp_pack(input logic s, input logic signed [9:0] e,
                                          input logic [23:0] sig, input logic g,
                                          input logic st);
    logic [24:0]       r;
    logic signed [9:0] ef;
    r  = {1'b0, sig} + {24'd0, g & (st | sig[0])};
    ef = e;
    if (r[24]) begin
      ef = e + 10'sd1;
      r  = r >> 1;
    end else begin
      ef = e;
    end
    if (ef >= 10'sd255) begin
      return {s, 8'hFF, 23'd0};
    end else if (ef <= 10'sd0) begin
      return {s, 31'd0};
    end else begin
      return {s, ef[7:0], r[22:0]};
    end
  endfunction

endpackage

// File: rtl/fp32_arith.sv
// fp32_arith: combinational IEEE-754 single-precision add or multiply.
// Round-to-nearest-even, denormals flushed to signed zero (in and out),
// overflow to +/-Inf, any NaN result is the canonical quiet NaN.
// Ports: op (FP_ADD/FP_MUL), x, y operands, z result.
module fp32_arith
  import neuron_pkg::*;
(
  input  fp_op_e      op,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] z
);

  logic [SIGN_W-1:0] xs_s, ys_s;
  logic [EXP_W-1:0]  xe_s, ye_s;
  logic [MANT_W-1:0] xm_s, ym_s;
  logic              xzero_s, yzero_s, xinf_s, yinf_s, xnan_s, ynan_s;

  assign {xs_s, xe_s, xm_s} = x;
  assign {ys_s, ye_s, ym_s} = y;
  assign xzero_s = (xe_s == 8'd0);
  assign yzero_s = (ye_s == 8'd0);
  assign xinf_s  = (xe_s == 8'hFF) && (xm_s == 23'd0);
  assign yinf_s  = (ye_s == 8'hFF) && (ym_s == 23'd0);
  assign xnan_s  = (xe_s == 8'hFF) && (xm_s != 23'd0);
  assign ynan_s  = (ye_s == 8'hFF) && (ym_s != 23'd0);

  // Multiply path: 24x24 significand product, leading one in bit 47 or 46
  logic [47:0]       prod_s;
  logic signed [9:0] mexp_s;
  assign prod_s = {1'b1, xm_s} * {1'b1, ym_s};
  assign mexp_s = $signed({2'b00, xe_s}) + $signed({2'b00, ye_s}) - 10'(EXP_BIAS);

  // Add path: order operands by magnitude so the result sign is the larger one's
  logic        big_sgn_s, sml_sgn_s;
  logic [7:0]  big_exp_s, sml_exp_s, dexp_s;
  logic [22:0] big_man_s, sml_man_s;

  // Operand swap for the adder
  always_comb begin
    if ({ye_s, ym_s} > {xe_s, xm_s}) begin
      big_sgn_s = ys_s; big_exp_s = ye_s; big_man_s = ym_s;
      sml_sgn_s = xs_s; sml_exp_s = xe_s; sml_man_s = xm_s;
    end else begin
      big_sgn_s = xs_s; big_exp_s = xe_s; big_man_s = xm_s;
      sml_sgn_s = ys_s; sml_exp_s = ye_s; sml_man_s = ym_s;
    end
  end

  // Significands carry three extra bits: guard, round, sticky
  logic [26:0] big_full_s, sml_full_s, sml_mask_s, sml_al_s, norm_s;
  logic [27:0] sum_s;
  logic [4:0]  lz_s;
  logic signed [9:0] aexp_s;

  assign dexp_s     = big_exp_s - sml_exp_s;
  assign big_full_s = {1'b1, big_man_s, 3'b000};
  assign sml_full_s = {1'b1, sml_man_s, 3'b000};

  // Align the smaller operand, folding shifted-out bits into the sticky bit
  always_comb begin
    sml_mask_s = 27'd0;
    if (dexp_s >= 8'd27) begin
      sml_al_s = 27'd1;
    end else begin
      sml_mask_s = (27'd1 << dexp_s[4:0]) - 27'd1;
      sml_al_s   = (sml_full_s >> dexp_s[4:0]) | {26'd0, |(sml_full_s & sml_mask_s)};
    end
  end

  assign sum_s = (big_sgn_s ^ sml_sgn_s) ? ({1'b0, big_full_s} - {1'b0, sml_al_s})
                                         : ({1'b0, big_full_s} + {1'b0, sml_al_s});
  assign lz_s  = lzc27(sum_s[26:0]);

  // Normalise the sum: one right shift on carry-out, else left by the zero count
  always_comb begin
    if (sum_s[27]) begin
      norm_s = {sum_s[27:2], sum_s[1] | sum_s[0]};
      aexp_s = $signed({2'b00, big_exp_s}) + 10'sd1;
    end else begin
      norm_s = sum_s[26:0] << lz_s;
      aexp_s = $signed({2'b00, big_exp_s}) - $signed({5'd0, lz_s});
    end
  end

  // Result select including the special-operand cases
  always_comb begin
    z = FP_QNAN;
    if (op == FP_MUL) begin
      if (xnan_s | ynan_s)                                z = FP_QNAN;
      else if ((xinf_s & yzero_s) | (xzero_s & yinf_s))   z = FP_QNAN;
      else if (xinf_s | yinf_s)                           z = {xs_s ^ ys_s, 8'hFF, 23'd0};
      else if (xzero_s | yzero_s)                         z = {xs_s ^ ys_s, 31'd0};
      else if (prod_s[47])
        z = fp_pack(xs_s ^ ys_s, mexp_s + 10'sd1, prod_s[47:24], prod_s[23], |prod_s[22:0]);
      else
        z = fp_pack(xs_s ^ ys_s, mexp_s, prod_s[46:23], prod_s[22], |prod_s[21:0]);
    end else begin
      if (xnan_s | ynan_s)                                z = FP_QNAN;
      else if (xinf_s & yinf_s & (xs_s != ys_s))          z = FP_QNAN;
      else if (xinf_s)                                    z = {xs_s, 8'hFF, 23'd0};
      else if (yinf_s)                                    z = {ys_s, 8'hFF, 23'd0};
      else if (xzero_s & yzero_s)                         z = {xs_s & ys_s, 31'd0};
      else if (xzero_s)                                   z = y;
      else if (yzero_s)                                   z = x;
      else if (sum_s == 28'd0)                            z = 32'd0;  // exact cancellation is +0
      else z = fp_pack(big_sgn_s, aexp_s, norm_s[26:3], norm_s[2], |norm_s[1:0]);
    end
  end

endmodule

// File: rtl/neuron.sv
// neuron: one Izhikevich spiking neuron, one forward-Euler step per CLK.
// Ports: CLK clock, RESET async active-high reset, I input current,
// a/b/c/d model parameters (all fp32), SPIKED registered spike flag.
// State V (membrane) and U (recovery) are fp32 registers.
module neuron
  import neuron_pkg::*;
#(
  parameter logic [31:0] V_INIT   = FP_NEG65,
  parameter logic [31:0] U_INIT   = FP_NEG13,
  parameter logic [31:0] V_THRESH = FP_30
)(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] I,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  output logic        SPIKED
);

  logic [31:0] V, U;
  logic [31:0] negu_s, vv_s, quad_s, lin_s, s1_s, s2_s, s3_s, s4_s, vn_s;
  logic [31:0] bv_s, bvu_s, abvu_s, un_s, und_s;
  logic        spike_s;

  // Subtracting U is adding U with its sign flipped
  assign negu_s = {~U[31], U[30:0]};

  // Vn = V + (((0.04*(V*V) + 5*V) + 140) - U + I), each op rounded in order
  fp32_arith u_vv   (.op(FP_MUL), .x(V),       .y(V),      .z(vv_s));
  fp32_arith u_quad (.op(FP_MUL), .x(FP_0P04), .y(vv_s),   .z(quad_s));
  fp32_arith u_lin  (.op(FP_MUL), .x(FP_5),    .y(V),      .z(lin_s));
  fp32_arith u_s1   (.op(FP_ADD), .x(quad_s),  .y(lin_s),  .z(s1_s));
  fp32_arith u_s2   (.op(FP_ADD), .x(s1_s),    .y(FP_140), .z(s2_s));
  fp32_arith u_s3   (.op(FP_ADD), .x(s2_s),    .y(negu_s), .z(s3_s));
  fp32_arith u_s4   (.op(FP_ADD), .x(s3_s),    .y(I),      .z(s4_s));
  fp32_arith u_vn   (.op(FP_ADD), .x(V),       .y(s4_s),   .z(vn_s));

  // Un = U + a*(b*V - U); post-spike U adds d on top of Un
  fp32_arith u_bv   (.op(FP_MUL), .x(b),       .y(V),      .z(bv_s));
  fp32_arith u_bvu  (.op(FP_ADD), .x(bv_s),    .y(negu_s), .z(bvu_s));
  fp32_arith u_abvu (.op(FP_MUL), .x(a),       .y(bvu_s),  .z(abvu_s));
  fp32_arith u_un   (.op(FP_ADD), .x(U),       .y(abvu_s), .z(un_s));
  fp32_arith u_und  (.op(FP_ADD), .x(un_s),    .y(d),      .z(und_s));

  // Threshold compare: threshold is positive, so only positive non-NaN Vn can
  // reach it and magnitude bits order like unsigned integers; -0 never spikes
  always_comb begin
    if ((vn_s[30:23] == 8'hFF) && (vn_s[22:0] != 23'd0)) begin
      spike_s = 1'b0;
    end else if (vn_s[31]) begin
      spike_s = 1'b0;
    end else begin
      spike_s = (vn_s[30:0] >= V_THRESH[30:0]);
    end
  end

  // State update: reset values, post-spike reset, or plain Euler step
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      V      <= V_INIT;
      U      <= U_INIT;
      SPIKED <= 1'b0;
    end else if (spike_s) begin
      V      <= c;
      U      <= und_s;
      SPIKED <= 1'b1;
    end else begin
      V      <= vn_s;
      U      <= un_s;
      SPIKED <= 1'b0;
    end
  end

endmodule

// File: tb/tb_neuron.sv
// tb_neuron: randomized self-checking bench for neuron. The reference model
// does each fp32 operation in double precision and rounds once to fp32.
module tb_neuron;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] I, a, b, c, d;
  logic        SPIKED;

  int tests_run = 0;
  int tests_failed = 0;
  int nspk, first_spk, cyc, nonfinite, rs_first;
  logic [31:0] mv, mu;
  logic        mspk;

  neuron dut (.CLK(CLK), .RESET(RESET), .I(I), .a(a), .b(b), .c(c), .d(d), .SPIKED(SPIKED));

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // fp32 bits -> real, denormals read as signed zero
  function automatic real f2r(input logic [31:0] f);
    logic [63:0] db;
    if (f[30:23] == 8'd0)
      db = {f[31], 63'd0};
    else if (f[30:23] == 8'hFF)
      db = (f[22:0] != 23'd0) ? {1'b0, 11'h7FF, 1'b1, 51'd0} : {f[31], 11'h7FF, 52'd0};
    else
      db = {f[31], {3'b000, f[30:23]} + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(db);
  endfunction

  // real -> fp32 with round-to-nearest-even, flush-to-zero and saturation
  function automatic logic [31:0] r2f(input real x);
    logic [63:0] db;
    logic [24:0] sig;
    int          e;
    db = $realtobits(x);
    if (db[62:52] == 11'h7FF) return (db[51:0] != 52'd0) ? 32'h7FC00000 : {db[63], 8'hFF, 23'd0};
    if (db[62:52] == 11'd0) return {db[63], 31'd0};
    e   = int'(db[62:52]) - 896;
    sig = {2'b01, db[51:29]} + {24'd0, db[28] & ((|db[27:0]) | db[29])};
    if (sig[24]) begin
      e   = e + 1;
      sig = sig >> 1;
    end
    if (e >= 255) return {db[63], 8'hFF, 23'd0};
    if (e <= 0) return {db[63], 31'd0};
    return {db[63], e[7:0], sig[22:0]};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
    return r2f(f2r(x) + f2r(y));
  endfunction
  function automatic logic [31:0] fsub(input logic [31:0] x, input logic [31:0] y);
    return fadd(x, {~y[31], y[30:0]});
  endfunction
  function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
    return r2f(f2r(x) * f2r(y));
  endfunction
  function automatic logic is_nan(input logic [31:0] f);
    return (f[30:23] == 8'hFF) && (f[22:0] != 23'd0);
  endfunction

  // One reference Euler step from model state and present inputs
  task automatic model_step(output logic [31:0] nv, output logic [31:0] nu, output logic ns);
    logic [31:0] vn, un;
    vn = fadd(mv, fadd(fsub(fadd(fadd(fmul(32'h3D23D70A, fmul(mv, mv)),
                                      fmul(32'h40A00000, mv)), 32'h430C0000), mu), I));
    un = fadd(mu, fmul(a, fsub(fmul(b, mv), mu)));
    ns = !is_nan(vn) && (f2r(vn) >= 30.0);
    if (ns) begin
      nv = c;
      nu = fadd(un, d);
    end else begin
      nv = vn;
      nu = un;
    end
  endtask

  task automatic phase_start();
    nspk = 0; first_spk = -1; cyc = 0; nonfinite = 0;
  endtask

  // Advance one edge and compare the full state with the model
  task automatic step(input string tag);
    logic [31:0] nv, nu;
    logic        ns;
    model_step(nv, nu, ns);
    @(posedge CLK);
    #1;
    mv = nv; mu = nu; mspk = ns;
    check({tag, "_V"}, dut.V, mv);
    check({tag, "_U"}, dut.U, mu);
    check({tag, "_spk"}, {31'd0, SPIKED}, {31'd0, mspk});
    if (SPIKED) begin
      nspk++;
      if (first_spk < 0) first_spk = cyc;
      check({tag, "_spkV_eq_c"}, dut.V, c);
    end
    if (dut.V[30:23] == 8'hFF || dut.U[30:23] == 8'hFF) nonfinite++;
    cyc++;
  endtask

  // Asynchronous reset raised mid-cycle, checked before any edge, held over one edge
  task automatic do_reset(input string tag);
    #2;
    RESET = 1'b1;
    #1;
    check({tag, "_async_V"}, dut.V, 32'hC2820000);
    check({tag, "_async_U"}, dut.U, 32'hC1500000);
    check({tag, "_async_spk"}, {31'd0, SPIKED}, 32'd0);
    @(posedge CLK);
    #1;
    check({tag, "_held_V"}, dut.V, 32'hC2820000);
    RESET = 1'b0;
    mv = 32'hC2820000; mu = 32'hC1500000; mspk = 1'b0;
  endtask

  task automatic set_params(input real ra, input real rb, input real rc, input real rd, input real ri);
    a = r2f(ra); b = r2f(rb); c = r2f(rc); d = r2f(rd); I = r2f(ri);
  endtask

  initial begin
    real vr;
    set_params(0.02, 0.2, -65.0, 8.0, 10.0);
    @(posedge CLK);
    #1;
    check("init_V", dut.V, 32'hC2820000);
    check("init_U", dut.U, 32'hC1500000);
    check("init_spk", {31'd0, SPIKED}, 32'd0);
    RESET = 1'b0;
    mv = 32'hC2820000; mu = 32'hC1500000; mspk = 1'b0;

    // Regular spiking: first step has known values, then it must spike
    phase_start();
    step("rs");
    check("rs_first_V", dut.V, 32'hC2680000);
    check("rs_first_U", dut.U, 32'hC1500000);
    for (int k = 1; k < 100; k++) step("rs");
    check("rs_spiked", {31'd0, nspk > 0}, 32'd1);
    rs_first = first_spk;

    // Fast spiking
    do_reset("fs_rst");
    set_params(0.1, 0.2, -65.0, 2.0, 10.0);
    phase_start();
    for (int k = 0; k < 100; k++) step("fs");
    check("fs_spiked", {31'd0, nspk > 0}, 32'd1);

    // Chattering: first spike no later than regular spiking
    do_reset("ch_rst");
    set_params(0.02, 0.2, -50.0, 2.0, 10.0);
    phase_start();
    for (int k = 0; k < 100; k++) step("ch");
    check("ch_spiked", {31'd0, nspk > 0}, 32'd1);
    check("ch_first_le_rs", {31'd0, (first_spk >= 0) && (first_spk <= rs_first)}, 32'd1);

    // Low-threshold spiking stays finite
    do_reset("lts_rst");
    set_params(0.02, 0.25, -65.0, 2.0, 5.0);
    phase_start();
    for (int k = 0; k < 100; k++) step("lts");
    check("lts_finite", nonfinite, 32'd0);

    // Rest: no input current, no spikes, V settles near the rest point
    do_reset("rest_rst");
    set_params(0.02, 0.2, -65.0, 8.0, 0.0);
    phase_start();
    for (int k = 0; k < 100; k++) step("rest");
    check("rest_nospk", nspk, 32'd0);
    vr = f2r(dut.V);
    check("rest_range", {31'd0, !is_nan(dut.V) && (vr > -75.0) && (vr < -60.0)}, 32'd1);

    // Current ramp with a reset in the middle
    do_reset("ramp_rst");
    phase_start();
    for (int k = 0; k < 150; k++) begin
      if (k == 75) do_reset("ramp_mid");
      I = r2f(real'(k / 10));
      step("ramp");
    end

    // Random parameters every cycle, with occasional denormal d and huge I
    do_reset("rnd_rst0");
    phase_start();
    for (int k = 0; k < 300; k++) begin
      set_params(real'($urandom_range(1, 10)) / 100.0, real'($urandom_range(15, 30)) / 100.0,
                 -real'($urandom_range(40, 70)), real'($urandom_range(0, 80)) / 10.0,
                 real'($urandom_range(0, 400)) / 10.0 - 5.0);
      if ($urandom_range(0, 15) == 0) d = 32'h00000005;
      if ($urandom_range(0, 39) == 0) I = r2f(($urandom_range(0, 1) == 1) ? 1.0e30 : -1.0e30);
      step("rnd");
      if (k % 60 == 59) do_reset("rnd_rst");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
